// File: rtl/audio_jitter_buf_rx_if.sv
// audio_jitter_buf_rx_if: UDP write-side and DAC read-side signal bundle for the audio jitter buffer.
`default_nettype none

interface audio_jitter_buf_rx_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              udp_rec_en;
  logic [DATA_W-1:0] udp_rec_data;
  logic              udp_rec_pkt_done;
  logic [ADDR_W:0]   wr_level;
  logic              ovf_drop;
  logic              aud_dac_req;
  logic [DATA_W-1:0] dac_data;
  logic              dac_valid;
  logic              playing;
  logic [15:0]       underrun_cnt;

  modport master (
    output udp_rec_en, udp_rec_data, udp_rec_pkt_done, aud_dac_req,
    input  wr_level, ovf_drop, dac_data, dac_valid, playing, underrun_cnt
  );

  modport slave (
    input  udp_rec_en, udp_rec_data, udp_rec_pkt_done, aud_dac_req,
    output wr_level, ovf_drop, dac_data, dac_valid, playing, underrun_cnt
  );
endinterface

`default_nettype wire

// File: rtl/audio_jitter_buf_rx.sv
// audio_jitter_buf_rx: async-FIFO jitter buffer from UDP receive (eth_rx_clk) to I2S DAC requests (aud_bclk),
// with prime-to-threshold playback, mute on underrun and drop on overflow.
`default_nettype none

module audio_jitter_buf_rx #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int START_LVL = 256,
  parameter int SYNC_STG  = 2
) (
  input  wire logic             eth_rx_clk,
  input  wire logic             aud_bclk,
  input  wire logic             rst_n,
  audio_jitter_buf_rx_if.slave  bus
);

  localparam int              PW        = ADDR_W + 1;
  localparam logic [ADDR_W:0] PTR_ONE   = PW'(1);
  localparam logic [ADDR_W:0] START_THR = PW'(START_LVL);

  typedef enum logic [0:0] {PRIME = 1'b0, PLAY = 1'b1} state_t;

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // ---------------- write domain ----------------
  logic [ADDR_W:0] wptr_bin, wptr_gray, wptr_nxt;
  logic [ADDR_W:0] rptr_sync [SYNC_STG];
  logic [ADDR_W:0] rptr_gray;
  logic            full, wr_ok, pkt_tgl;

  assign full     = (wptr_gray == {~rptr_sync[SYNC_STG-1][ADDR_W:ADDR_W-1],
                                    rptr_sync[SYNC_STG-1][ADDR_W-2:0]});
  assign wr_ok    = bus.udp_rec_en & ~full;
  assign wptr_nxt = wr_ok ? wptr_bin + PTR_ONE : wptr_bin;

  always_ff @(posedge eth_rx_clk) begin
    if (wr_ok) mem[wptr_bin[ADDR_W-1:0]] <= bus.udp_rec_data;
  end

  always_ff @(posedge eth_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin     <= '0;
      wptr_gray    <= '0;
      bus.ovf_drop <= 1'b0;
      bus.wr_level <= '0;
      pkt_tgl      <= 1'b0;
      for (int i = 0; i < SYNC_STG; i++) rptr_sync[i] <= '0;
    end else begin
      wptr_bin     <= wptr_nxt;
      wptr_gray    <= bin2gray(wptr_nxt);
      rptr_sync[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STG; i++) rptr_sync[i] <= rptr_sync[i-1];
      bus.ovf_drop <= bus.udp_rec_en & full;
      bus.wr_level <= wptr_nxt - gray2bin(rptr_sync[SYNC_STG-1]);
      if (bus.udp_rec_pkt_done) pkt_tgl <= ~pkt_tgl;
    end
  end

  // ---------------- read domain ----------------
  logic [ADDR_W:0] rptr_bin, rd_level;
  logic [ADDR_W:0] wptr_sync [SYNC_STG];
  logic [SYNC_STG:0] pkt_sync;
  logic            pkt_edge, pkt_seen, empty, pop, underrun;
  state_t          state, state_nxt;

  assign pkt_edge    = pkt_sync[SYNC_STG] ^ pkt_sync[SYNC_STG-1];
  assign rd_level    = gray2bin(wptr_sync[SYNC_STG-1]) - rptr_bin;
  assign empty       = (rptr_gray == wptr_sync[SYNC_STG-1]);
  assign bus.playing = (state == PLAY);

  // A threshold crossing coinciding with a request leaves that request muted in PRIME.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    underrun  = 1'b0;
    case (state)
      PRIME: begin
        if (pkt_seen && (rd_level >= START_THR)) state_nxt = PLAY;
      end
      PLAY: begin
        if (bus.aud_dac_req) begin
          if (empty) begin
            underrun  = 1'b1;
            state_nxt = PRIME;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= PRIME;
      rptr_bin         <= '0;
      rptr_gray        <= '0;
      pkt_sync         <= '0;
      pkt_seen         <= 1'b0;
      bus.dac_data     <= '0;
      bus.dac_valid    <= 1'b0;
      bus.underrun_cnt <= '0;
      for (int i = 0; i < SYNC_STG; i++) wptr_sync[i] <= '0;
    end else begin
      state        <= state_nxt;
      wptr_sync[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STG; i++) wptr_sync[i] <= wptr_sync[i-1];
      pkt_sync      <= {pkt_sync[SYNC_STG-1:0], pkt_tgl};
      // A packet edge landing on the underrun cycle still counts toward re-priming.
      pkt_seen      <= pkt_edge | (pkt_seen & ~underrun);
      bus.dac_valid <= bus.aud_dac_req;
      if (pop) begin
        bus.dac_data <= mem[rptr_bin[ADDR_W-1:0]];
        rptr_bin     <= rptr_bin + PTR_ONE;
        rptr_gray    <= bin2gray(rptr_bin + PTR_ONE);
      end else if (bus.aud_dac_req) begin
        bus.dac_data <= '0;
      end
      if (underrun && (bus.underrun_cnt != 16'hFFFF))
        bus.underrun_cnt <= bus.underrun_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_jitter_buf_rx.sv
// tb_audio_jitter_buf_rx: directed self-checking bench for audio_jitter_buf_rx.
`timescale 1ns/1ps
`default_nettype none

module tb_audio_jitter_buf_rx;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int START_LVL = 256;
  localparam int SYNC_STG  = 2;

  logic eth_rx_clk = 1'b0;
  logic aud_bclk   = 1'b0;
  logic rst_n      = 1'b0;

  int tests     = 0;
  int fails     = 0;
  int ovf_count = 0;
  int ovf0;
  int n;
  int guard;
  logic        stall;
  logic [31:0] rd_d;
  logic        rd_v;

  audio_jitter_buf_rx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  audio_jitter_buf_rx #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .START_LVL(START_LVL), .SYNC_STG(SYNC_STG)
  ) dut (
    .eth_rx_clk(eth_rx_clk),
    .aud_bclk  (aud_bclk),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  always #4  eth_rx_clk = ~eth_rx_clk;
  always #20 aud_bclk   = ~aud_bclk;

  always @(posedge eth_rx_clk) if (bus.ovf_drop === 1'b1) ovf_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge eth_rx_clk);
      bus.udp_rec_en   = 1'b1;
      bus.udp_rec_data = 32'(base + i);
    end
    @(negedge eth_rx_clk);
    bus.udp_rec_en = 1'b0;
  endtask

  task automatic pkt_done();
    @(negedge eth_rx_clk);
    bus.udp_rec_pkt_done = 1'b1;
    @(negedge eth_rx_clk);
    bus.udp_rec_pkt_done = 1'b0;
  endtask

  task automatic req(output logic [31:0] d, output logic v);
    @(negedge aud_bclk);
    bus.aud_dac_req = 1'b1;
    @(negedge aud_bclk);
    bus.aud_dac_req = 1'b0;
    d = bus.dac_data;
    v = bus.dac_valid;
  endtask

  task automatic wait_bclk(input int cyc);
    repeat (cyc) @(negedge aud_bclk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.udp_rec_en       = 1'b0;
    bus.udp_rec_data     = '0;
    bus.udp_rec_pkt_done = 1'b0;
    bus.aud_dac_req      = 1'b0;
    stall                = 1'b0;

    // Reset values
    wait_bclk(3);
    check("rst_wr_level", 32'(bus.wr_level), 0);
    check("rst_ovf", 32'(bus.ovf_drop), 0);
    check("rst_dac_data", bus.dac_data, 0);
    check("rst_dac_valid", 32'(bus.dac_valid), 0);
    check("rst_playing", 32'(bus.playing), 0);
    check("rst_underrun", 32'(bus.underrun_cnt), 0);
    @(negedge aud_bclk);
    rst_n = 1'b1;
    wait_bclk(2);

    // Test 1: 300 words, mute while priming, then in-order playback
    wr_burst(0, 300);
    wait_bclk(6);
    check("t1_wr_level", 32'(bus.wr_level), 300);
    req(rd_d, rd_v);
    check("t1_prime_mute_data", rd_d, 0);
    check("t1_prime_mute_valid", 32'(rd_v), 1);
    check("t1_no_play_wo_pkt", 32'(bus.playing), 0);
    pkt_done();
    wait_bclk(6);
    check("t1_playing", 32'(bus.playing), 1);
    for (int i = 0; i < 300; i++) begin
      req(rd_d, rd_v);
      check("t1_data", rd_d, 32'(i));
      check("t1_valid", 32'(rd_v), 1);
    end
    @(negedge aud_bclk);
    check("t1_valid_pulse_drops", 32'(bus.dac_valid), 0);
    check("t1_data_holds", bus.dac_data, 299);

    // Test 3: 10 buffered words, 12 requests
    wr_burst(1000, 10);
    wait_bclk(6);
    for (int i = 0; i < 10; i++) begin
      req(rd_d, rd_v);
      check("t3_data", rd_d, 32'(1000 + i));
    end
    req(rd_d, rd_v);
    check("t3_underrun_mute", rd_d, 0);
    check("t3_underrun_valid", 32'(rd_v), 1);
    check("t3_underrun_cnt", 32'(bus.underrun_cnt), 1);
    check("t3_playing", 32'(bus.playing), 0);
    req(rd_d, rd_v);
    check("t3_prime_mute", rd_d, 0);
    check("t3_underrun_cnt_hold", 32'(bus.underrun_cnt), 1);
    wait_bclk(4);
    check("t3_wr_level_empty", 32'(bus.wr_level), 0);

    // Test 4: threshold reached without packet end stays PRIME
    wr_burst(2000, 256);
    wait_bclk(10);
    check("t4_no_pkt_prime", 32'(bus.playing), 0);
    pkt_done();
    n = 0;
    while (!bus.playing && n < SYNC_STG + 2) begin
      @(posedge aud_bclk);
      #1;
      n++;
    end
    check("t4_play_latency", 32'(bus.playing), 1);
    for (int i = 0; i < 256; i++) begin
      req(rd_d, rd_v);
      check("t4_data", rd_d, 32'(2000 + i));
    end

    // Test 2: overflow drops the extra words
    ovf0 = ovf_count;
    wr_burst(3000, 516);
    repeat (4) @(negedge eth_rx_clk);
    check("t2_ovf_pulses", 32'(ovf_count - ovf0), 4);
    check("t2_wr_level_full", 32'(bus.wr_level), 512);
    check("t2_ovf_idle", 32'(bus.ovf_drop), 0);
    wait_bclk(4);
    for (int i = 0; i < 512; i++) begin
      req(rd_d, rd_v);
      check("t2_data", rd_d, 32'(3000 + i));
    end
    req(rd_d, rd_v);
    check("t2_no_extra_word", rd_d, 0);
    check("t2_underrun_cnt", 32'(bus.underrun_cnt), 2);
    check("t2_playing", 32'(bus.playing), 0);

    // Test 5: concurrent streaming across several pointer wraps
    ovf0 = ovf_count;
    fork
      begin
        for (int k = 0; k < 1800; k++) begin
          @(negedge eth_rx_clk);
          guard = 0;
          while (bus.wr_level >= 10'd480 && guard < 20000) begin
            bus.udp_rec_en       = 1'b0;
            bus.udp_rec_pkt_done = 1'b0;
            @(negedge eth_rx_clk);
            guard++;
          end
          if (guard >= 20000) stall = 1'b1;
          bus.udp_rec_en       = 1'b1;
          bus.udp_rec_data     = 32'(4000 + k);
          bus.udp_rec_pkt_done = (k == 300);
        end
        @(negedge eth_rx_clk);
        bus.udp_rec_en       = 1'b0;
        bus.udp_rec_pkt_done = 1'b0;
      end
      begin
        n = 0;
        while (!bus.playing && n < 2000) begin
          @(negedge aud_bclk);
          n++;
        end
        check("t5_playing", 32'(bus.playing), 1);
        for (int j = 0; j < 1500; j++) begin
          req(rd_d, rd_v);
          check("t5_stream", rd_d, 32'(4000 + j));
        end
      end
    join
    check("t5_writer_stall", 32'(stall), 0);
    check("t5_no_ovf", 32'(ovf_count - ovf0), 0);
    check("t5_no_underrun", 32'(bus.underrun_cnt), 2);
    check("t5_still_playing", 32'(bus.playing), 1);

    // Test 6: reset mid-stream discards buffered data
    @(negedge eth_rx_clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_wr_level", 32'(bus.wr_level), 0);
    check("t6_ovf", 32'(bus.ovf_drop), 0);
    check("t6_dac_data", bus.dac_data, 0);
    check("t6_dac_valid", 32'(bus.dac_valid), 0);
    check("t6_playing", 32'(bus.playing), 0);
    check("t6_underrun", 32'(bus.underrun_cnt), 0);
    wait_bclk(2);
    rst_n = 1'b1;
    wait_bclk(2);
    req(rd_d, rd_v);
    check("t6_prime_mute", rd_d, 0);
    check("t6_prime_state", 32'(bus.playing), 0);
    wr_burst(5000, 300);
    pkt_done();
    wait_bclk(8);
    check("t6_replay", 32'(bus.playing), 1);
    for (int i = 0; i < 300; i++) begin
      req(rd_d, rd_v);
      check("t6_data", rd_d, 32'(5000 + i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
